mips_ctrl_fsm: RTL and testbench
================================

Name: mips_ctrl_fsm

Overview:
- Multicycle MIPS32 control unit: latches the 6-bit opcode and funct of each fetched instruction and steps a Moore FSM through FETCH/DECODE/EXEC/MEM/WB.
- Drives registered datapath enables and the ALU operation code.
- Handles memory-ready stalls with a bounded timeout, and flags illegal opcodes.
- Sits between instruction memory / data memory handshakes and the datapath (register file, ALU, PC).

Parameters:
OPW, 6, opcode and funct width in bits
ALUOPW, 4, width of alu_op output
TMO_W, 4, width of memory-wait timeout counter
MEM_TMO, 15, cycles waited on mem_ready before the timeout error (must be < 2**TMO_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction word present on opcode/funct
opcode  in  OPW  instruction bits [31:26]
funct  in  OPW  instruction bits [5:0]
mem_ready  in  1  memory access complete (instruction fetch or data)
alu_zero  in  1  ALU zero flag for branch resolution
ir_write  out  1  load instruction register
pc_write  out  1  update PC (sequential, branch taken or jump)
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
reg_write  out  1  register file write enable
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  writeback source is memory
mem_read  out  1  data memory read strobe
mem_write  out  1  data memory write strobe
alu_src  out  1  1 = sign-extended immediate, 0 = rt
alu_op  out  ALUOPW  0 = add, 1 = sub, 2 = and, 3 = or, 4 = slt, 15 = nop
illegal  out  1  one-cycle pulse on unsupported opcode or funct
mem_tmo  out  1  one-cycle pulse on memory timeout
state  out  3  current FSM state, for debug

Behaviour:
- Reset: state = FETCH (3'd1); latched opcode/funct = 0; timeout counter = 0; all outputs 0 except alu_op = 15. rst overrides any in-flight access; the next cycle starts a fresh FETCH.
- State encodings:
  - FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5.
  - Encodings 0, 6 and 7 are unreachable; if entered, the FSM goes to FETCH next cycle.
- All outputs are registered. Each is a function of the next state and the latched opcode, so it is valid during the cycle that state is held.
- FETCH:
  - Waits for instr_valid && mem_ready.
  - On the capture cycle: latch opcode/funct, pulse ir_write, go to DECODE.
  - Each cycle without mem_ready increments the counter. When it reaches MEM_TMO: pulse mem_tmo, clear the counter, stay in FETCH.
- DECODE:
  - Supported opcodes: 000000 R-type; 001001 ADDIU; 100011 LW; 101011 SW; 000100 BEQ; 000010 J.
  - J: pc_write = 1, pc_src = 2, then FETCH.
  - Unsupported opcode, or R-type funct not in {100001 addu, 100011 subu, 100100 and, 100101 or, 101010 slt}: pulse illegal, pc_write = 1, pc_src = 0, then FETCH.
  - All other supported opcodes go to EXEC.
- EXEC:
  - R-type: alu_op from funct, reg_dst = 1, alu_src = 0; go to WB.
  - ADDIU, LW, SW: alu_op = 0, alu_src = 1. ADDIU goes to WB; LW and SW go to MEM.
  - BEQ: alu_op = 1. pc_write = 1 with pc_src = 1 if alu_zero, else pc_src = 0. Then FETCH.
- MEM:
  - mem_read (LW) or mem_write (SW) is held until mem_ready.
  - Timeout behaviour is the same as in FETCH, except that after mem_tmo the FSM abandons the access and goes to FETCH with no PC update.
  - On mem_ready: LW goes to WB; SW sets pc_write = 1, pc_src = 0, then FETCH.
- WB:
  - reg_write = 1 for one cycle; mem_to_reg = 1 for LW only; pc_write = 1, pc_src = 0.
  - Then FETCH.
- Latency in cycles, excluding stalls: J = 2, BEQ = 3, R/ADDIU = 4, SW = 4, LW = 5.
- reg_write, mem_write and pc_write are never asserted in the same cycle.
- The counter clears on every state change.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings;
  - opcode constants OP_RTYPE, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J;
  - funct constants;
  - ALU op codes.
- One sub-module, mips_alu_dec: combinational mapping (opcode, funct) to (alu_op, legal). It is reused by the later pipelined control.

Test Plan:
- Reset mid-MEM of LW (rst high 1 cycle) -> next cycle state = 1, alu_op = 15, all enables 0.
- ADDIU (opcode 001001), mem_ready = 1 -> state sequence 1,2,3,5,1; alu_src = 1, alu_op = 0 in EXEC; reg_write = 1, reg_dst = 0 in WB.
- LW with mem_ready delayed 3 cycles in MEM -> mem_read held 4 cycles; WB with mem_to_reg = 1; total 8 cycles.
- BEQ with alu_zero = 1, then again with alu_zero = 0 -> pc_src = 1, then pc_src = 0; pc_write = 1 in EXEC both times; back to FETCH after 3 cycles.
- Opcode 111111, and R-type with funct 000000 -> illegal pulses in DECODE, pc_src = 0, no reg_write.
- mem_ready held low 15 cycles in FETCH -> mem_tmo pulses on cycle 15 and state stays 1; in MEM for SW -> mem_tmo, then FETCH with no pc_write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared encodings for the MIPS32 control path (states, opcodes,
//            funct codes, ALU operations, PC source selects).
// Revision : 1.0
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_NOP  = 4'd15;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mips_alu_dec.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_dec
// Purpose  : Combinational (opcode, funct) -> (ALU operation, legal) decode.
// Revision : 1.0
// ============================================================================
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       legal_o
);

    always_comb begin
        alu_op_o = ALU_NOP;
        legal_o  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                legal_o = 1'b1;
                case (funct_i)
                    FN_ADDU: alu_op_o = ALU_ADD;
                    FN_SUBU: alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    default: legal_o  = 1'b0;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW: begin
                legal_o  = 1'b1;
                alu_op_o = ALU_ADD;
            end
            OP_BEQ: begin
                legal_o  = 1'b1;
                alu_op_o = ALU_SUB;
            end
            OP_J: begin
                legal_o  = 1'b1;
            end
            default: begin
                legal_o  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_fsm
// Purpose  : Multicycle MIPS32 control FSM with registered datapath enables,
//            memory-wait timeout and illegal-instruction flagging.
// Revision : 1.0
// ============================================================================
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int ALUOPW  = 4,
    parameter int TMO_W   = 4,
    parameter int MEM_TMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid_i,
    input  logic [OPW-1:0]    opcode_i,
    input  logic [OPW-1:0]    funct_i,
    input  logic              mem_ready_i,
    input  logic              alu_zero_i,
    output logic              ir_write_o,
    output logic              pc_write_o,
    output logic [1:0]        pc_src_o,
    output logic              reg_write_o,
    output logic              reg_dst_o,
    output logic              mem_to_reg_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              alu_src_o,
    output logic [ALUOPW-1:0] alu_op_o,
    output logic              illegal_o,
    output logic              mem_tmo_o,
    output logic [2:0]        state_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    state_e              state_q;
    logic [OPW-1:0]      opcode_q;
    logic [OPW-1:0]      funct_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic                ir_write_q, pc_write_q, reg_write_q, reg_dst_q;
    logic                mem_to_reg_q, mem_read_q, mem_write_q, alu_src_q;
    logic                illegal_q, mem_tmo_q;
    logic [1:0]          pc_src_q;
    logic [ALUOPW-1:0]   alu_op_q;

    logic [OPW-1:0]      w_dec_opcode;
    logic [OPW-1:0]      w_dec_funct;
    logic [3:0]          w_alu_op;
    logic                w_legal;
    logic                w_is_rtype, w_is_lw, w_is_sw, w_is_beq;
    logic                w_tmo_hit;
    logic [TMO_W-1:0]    w_cnt_inc;

    // While fetching, decode the incoming word so DECODE outputs are ready on entry.
    assign w_dec_opcode = (state_q == ST_FETCH) ? opcode_i : opcode_q;
    assign w_dec_funct  = (state_q == ST_FETCH) ? funct_i  : funct_q;

    mips_alu_dec u_alu_dec (
        .opcode_i (6'(w_dec_opcode)),
        .funct_i  (6'(w_dec_funct)),
        .alu_op_o (w_alu_op),
        .legal_o  (w_legal)
    );

    assign w_is_rtype = (opcode_q == OP_RTYPE);
    assign w_is_lw    = (opcode_q == OP_LW);
    assign w_is_sw    = (opcode_q == OP_SW);
    assign w_is_beq   = (opcode_q == OP_BEQ);
    assign w_tmo_hit  = (tmo_cnt_q == TMO_LAST);
    assign w_cnt_inc  = tmo_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            opcode_q     <= '0;
            funct_q      <= '0;
            tmo_cnt_q    <= '0;
            ir_write_q   <= 1'b0;
            pc_write_q   <= 1'b0;
            pc_src_q     <= PC_SEQ;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= ALUOPW'(ALU_NOP);
            illegal_q    <= 1'b0;
            mem_tmo_q    <= 1'b0;
        end else begin
            ir_write_q   <= 1'b0;
            pc_write_q   <= 1'b0;
            pc_src_q     <= PC_SEQ;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= ALUOPW'(ALU_NOP);
            illegal_q    <= 1'b0;
            mem_tmo_q    <= 1'b0;
            tmo_cnt_q    <= '0;
            case (state_q)
                ST_FETCH: begin
                    if (instr_valid_i && mem_ready_i) begin
                        state_q    <= ST_DECODE;
                        opcode_q   <= opcode_i;
                        funct_q    <= funct_i;
                        ir_write_q <= 1'b1;
                        if (!w_legal) begin
                            illegal_q  <= 1'b1;
                            pc_write_q <= 1'b1;
                        end else if (opcode_i == OP_J) begin
                            pc_write_q <= 1'b1;
                            pc_src_q   <= PC_JUMP;
                        end
                    end else if (!mem_ready_i) begin
                        if (w_tmo_hit) begin
                            mem_tmo_q <= 1'b1;
                        end else begin
                            tmo_cnt_q <= w_cnt_inc;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q;
                    end
                end
                ST_DECODE: begin
                    if (!w_legal || opcode_q == OP_J) begin
                        state_q <= ST_FETCH;
                    end else begin
                        state_q  <= ST_EXEC;
                        alu_op_q <= ALUOPW'(w_alu_op);
                        if (w_is_rtype) begin
                            reg_dst_q <= 1'b1;
                        end else if (w_is_beq) begin
                            // Branch resolved on entry so pc_src is stable for all of EXEC.
                            pc_write_q <= 1'b1;
                            pc_src_q   <= alu_zero_i ? PC_BRANCH : PC_SEQ;
                        end else begin
                            alu_src_q <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (w_is_lw) begin
                        state_q    <= ST_MEM;
                        mem_read_q <= 1'b1;
                    end else if (w_is_sw) begin
                        state_q     <= ST_MEM;
                        mem_write_q <= 1'b1;
                    end else if (w_is_beq) begin
                        state_q <= ST_FETCH;
                    end else begin
                        state_q     <= ST_WB;
                        reg_write_q <= 1'b1;
                        reg_dst_q   <= w_is_rtype;
                    end
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        if (w_is_lw) begin
                            state_q      <= ST_WB;
                            reg_write_q  <= 1'b1;
                            mem_to_reg_q <= 1'b1;
                        end else begin
                            state_q    <= ST_FETCH;
                            pc_write_q <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        state_q   <= ST_FETCH;
                        mem_tmo_q <= 1'b1;
                    end else begin
                        tmo_cnt_q   <= w_cnt_inc;
                        mem_read_q  <= mem_read_q;
                        mem_write_q <= mem_write_q;
                    end
                end
                ST_WB: begin
                    // PC advance lands in the following FETCH cycle, never alongside reg_write.
                    state_q    <= ST_FETCH;
                    pc_write_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign ir_write_o   = ir_write_q;
    assign pc_write_o   = pc_write_q;
    assign pc_src_o     = pc_src_q;
    assign reg_write_o  = reg_write_q;
    assign reg_dst_o    = reg_dst_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign alu_src_o    = alu_src_q;
    assign alu_op_o     = alu_op_q;
    assign illegal_o    = illegal_q;
    assign mem_tmo_o    = mem_tmo_q;
    assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_ctrl_fsm
// Purpose  : Self-checking scoreboard bench for the multicycle control FSM.
// Revision : 1.0
// ============================================================================
module tb_mips_ctrl_fsm;

    localparam int MEM_TMO = 15;

    typedef logic [18:0] vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, mem_ready, alu_zero;
    logic [5:0]  opcode, funct;
    logic        ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic        mem_read, mem_write, alu_src, illegal, mem_tmo;
    logic [1:0]  pc_src;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    vec_t        exp_q[$];
    vec_t        w_act;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mips_ctrl_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid_i(instr_valid),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .mem_ready_i  (mem_ready),
        .alu_zero_i   (alu_zero),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .alu_src_o    (alu_src),
        .alu_op_o     (alu_op),
        .illegal_o    (illegal),
        .mem_tmo_o    (mem_tmo),
        .state_o      (state)
    );

    assign w_act = {state, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
                    mem_read, mem_write, alu_src, alu_op, illegal, mem_tmo};

    function automatic vec_t v(input logic [2:0] st, input logic ir, pcw,
                               input logic [1:0] pcs, input logic rw, rd, m2r, mr, mw, as,
                               input logic [3:0] aop, input logic ill, tmo);
        return {st, ir, pcw, pcs, rw, rd, m2r, mr, mw, as, aop, ill, tmo};
    endfunction

    function automatic vec_t idle(input logic pcw, input logic tmo);
        return v(3'd1, 1'b0, pcw, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, tmo);
    endfunction

    // Reference decode: {legal, alu_op}
    function automatic logic [4:0] model_dec(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: return {1'b1, 4'd0};
                    6'b100011: return {1'b1, 4'd1};
                    6'b100100: return {1'b1, 4'd2};
                    6'b100101: return {1'b1, 4'd3};
                    6'b101010: return {1'b1, 4'd4};
                    default:   return {1'b0, 4'd15};
                endcase
            end
            6'b001001, 6'b100011, 6'b101011: return {1'b1, 4'd0};
            6'b000100: return {1'b1, 4'd1};
            6'b000010: return {1'b1, 4'd15};
            default:   return {1'b0, 4'd15};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, 32'(w_act), 32'(e));
        chk({tag, ".excl"}, 32'((reg_write & mem_write) | (reg_write & pc_write) |
                                (mem_write & pc_write)), 32'd0);
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int wait_n);
        logic [4:0] d;
        logic       ill, is_j, is_r, is_beq, is_lw, is_sw;
        int         n, n_wait;
        d      = model_dec(op, fn);
        ill    = !d[4];
        is_j   = (op == 6'b000010);
        is_r   = (op == 6'b000000);
        is_beq = (op == 6'b000100);
        is_lw  = (op == 6'b100011);
        is_sw  = (op == 6'b101011);
        n_wait = (wait_n < MEM_TMO) ? wait_n : MEM_TMO;
        exp_q.push_back(v(3'd2, 1'b1, ill || is_j, is_j ? 2'd2 : 2'd0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 4'd15, ill, 1'b0));
        if (!ill && !is_j) begin
            exp_q.push_back(v(3'd3, 1'b0, is_beq, (is_beq && zero) ? 2'd1 : 2'd0, 1'b0, is_r,
                              1'b0, 1'b0, 1'b0, !is_r && !is_beq, d[3:0], 1'b0, 1'b0));
            if (is_lw || is_sw) begin
                for (int k = 0; k < ((wait_n < MEM_TMO) ? wait_n + 1 : MEM_TMO); k++)
                    exp_q.push_back(v(3'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, is_lw, is_sw,
                                      1'b0, 4'd15, 1'b0, 1'b0));
                if (wait_n >= MEM_TMO) begin
                    exp_q.push_back(idle(1'b0, 1'b1));
                end else if (is_lw) begin
                    exp_q.push_back(v(3'd5, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                      1'b0, 4'd15, 1'b0, 1'b0));
                    exp_q.push_back(idle(1'b1, 1'b0));
                end else begin
                    exp_q.push_back(idle(1'b1, 1'b0));
                end
            end else if (!is_beq) begin
                exp_q.push_back(v(3'd5, 1'b0, 1'b0, 2'd0, 1'b1, is_r, 1'b0, 1'b0, 1'b0,
                                  1'b0, 4'd15, 1'b0, 1'b0));
                exp_q.push_back(idle(1'b1, 1'b0));
            end
        end
        exp_q.push_back(idle(1'b0, 1'b0));
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            instr_valid = (i == 1);
            opcode      = op;
            funct       = fn;
            alu_zero    = zero;
            mem_ready   = !(i >= 4 && i < 4 + n_wait);
            step($sformatf("%s.c%0d", name, i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] fns [5];
        fns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0;
        opcode = 6'd0; funct = 6'd0;
        exp_q.push_back(idle(1'b0, 1'b0)); step("reset");
        exp_q.push_back(idle(1'b0, 1'b0)); step("reset.hold");
        rst = 1'b0;

        run_instr("addiu", 6'b001001, 6'b000000, 1'b0, 0);
        for (int k = 0; k < 5; k++)
            run_instr($sformatf("rtype%0d", k), 6'b000000, fns[k], 1'b0, 0);
        run_instr("lw_wait3", 6'b100011, 6'b000000, 1'b0, 3);
        run_instr("sw", 6'b101011, 6'b000000, 1'b0, 0);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, 0);
        run_instr("beq_not", 6'b000100, 6'b000000, 1'b0, 0);
        run_instr("jump", 6'b000010, 6'b000000, 1'b0, 0);
        run_instr("ill_op", 6'b111111, 6'b000000, 1'b0, 0);
        run_instr("ill_fn", 6'b000000, 6'b000000, 1'b0, 0);
        run_instr("sw_tmo", 6'b101011, 6'b000000, 1'b0, 15);

        // Reset while an LW is waiting in MEM
        instr_valid = 1'b1; opcode = 6'b100011; funct = 6'd0; mem_ready = 1'b1;
        exp_q.push_back(v(3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          4'd15, 1'b0, 1'b0));
        step("rstmem.dec");
        instr_valid = 1'b0;
        exp_q.push_back(v(3'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                          4'd0, 1'b0, 1'b0));
        step("rstmem.exec");
        exp_q.push_back(v(3'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                          4'd15, 1'b0, 1'b0));
        step("rstmem.mem0");
        mem_ready = 1'b0;
        exp_q.push_back(v(3'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                          4'd15, 1'b0, 1'b0));
        step("rstmem.mem1");
        rst = 1'b1;
        exp_q.push_back(idle(1'b0, 1'b0)); step("rstmem.reset");
        rst = 1'b0;

        // FETCH starved of mem_ready: pulse after the 15th idle cycle, state stays FETCH
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(idle(1'b0, i == MEM_TMO));
            step($sformatf("ftmo.c%0d", i));
        end
        mem_ready = 1'b1;
        exp_q.push_back(idle(1'b0, 1'b0)); step("ftmo.end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
